// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
//   Time-shares the 4-digit 7-seg display between N_SRC requesters.
//   Round-robin arbitration, each grant held for DWELL_CYCLES while others
//   wait; a lone requester keeps the display indefinitely. Outputs are the
//   digit/dot nibbles feeding the quad-digit mux (no segment timing here).
//
//   Optional feature macro: SEG_BLANK_GAP_EN
//     defined   -> GAP_CYCLES blank cycles between different owners
//     undefined -> back-to-back hand-over, no GAP state/counter
//
// Ports
//   clk       in   system clock, posedge
//   reset     in   synchronous, active-high
//   req       in   [N_SRC-1:0] level request per source
//   src_data  in   [16*N_SRC-1:0] source i digits at [16i+15:16i], nibble 3 leftmost
//   src_dots  in   [4*N_SRC-1:0]  source i dots at [4i+3:4i], bit 3 leftmost
//   gnt       out  [N_SRC-1:0] one-hot registered grant, 0 when nothing shown
//   active    out  a source owns the display
//   num3..0   out  [3:0] hex digits, num3 leftmost
//   dot_out   out  [3:0] decimal points, active-high, [3] leftmost
module seg_display_scheduler #(
   parameter int N_SRC        = 4,
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int GAP_CYCLES   = 5_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_SRC-1:0]      req,
   input  logic [16*N_SRC-1:0]   src_data,
   input  logic [4*N_SRC-1:0]    src_dots,
   output logic [N_SRC-1:0]      gnt,
   output logic                  active,
   output logic [3:0]            num3,
   output logic [3:0]            num2,
   output logic [3:0]            num1,
   output logic [3:0]            num0,
   output logic [3:0]            dot_out
);

   localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int CW = $clog2(DWELL_CYCLES + 1);
   localparam logic [N_SRC-1:0] ONE      = N_SRC'(1);
   localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL_CYCLES - 1);

   if (N_SRC < 2 || N_SRC > 8 || DWELL_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_param
      $error("seg_display_scheduler: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      SHOW
`ifdef SEG_BLANK_GAP_EN
      , GAP
`endif
   } state_t;

   state_t            state;
   logic [IW-1:0]     ptr;     // last winner; equals current owner while SHOW
   logic [CW-1:0]     cnt;
`ifdef SEG_BLANK_GAP_EN
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   logic [GW-1:0]     gcnt;
   logic              go_gap;
`endif

   // Round-robin search starting after ptr; ptr itself is checked last.
   logic              found;
   logic [IW-1:0]     win;
   logic [IW-1:0]     cand;
   always_comb begin
      found = 1'b0;
      win   = ptr;
      cand  = '0;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = IW'((int'(ptr) + k) % N_SRC);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   logic others, expire, take, go_idle, keep, handover;
   assign others = |(req & ~(ONE << ptr));
   assign expire = (cnt == CNT_LAST);

   always_comb begin
      take     = 1'b0;
      go_idle  = 1'b0;
      keep     = 1'b0;
      handover = 1'b0;
      case (state)
         IDLE: take = found;
         SHOW: begin
            // A drop wins over a coinciding expiry.
            if (!req[ptr]) begin
               if (found) handover = 1'b1;
               else       go_idle  = 1'b1;
            end else if (expire) begin
               if (others) handover = 1'b1;
               else        keep     = 1'b1;
            end
         end
`ifdef SEG_BLANK_GAP_EN
         GAP: begin
            if (gcnt == GAP_LAST) begin
               if (found) take    = 1'b1;
               else       go_idle = 1'b1;
            end
         end
`endif
         default: ;
      endcase
`ifdef SEG_BLANK_GAP_EN
      go_gap = handover;
`else
      take = take | handover;
`endif
   end

   // Source whose digits are latched this edge: the new winner on a grant,
   // otherwise the current owner (live data while SHOW).
   logic [IW-1:0] sel_idx;
   logic [15:0]   sel_data;
   logic [3:0]    sel_dots;
   assign sel_idx  = take ? win : ptr;
   assign sel_data = src_data[{sel_idx, 4'b0000} +: 16];
   assign sel_dots = src_dots[{sel_idx, 2'b00} +: 4];

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= IW'(N_SRC - 1);
         cnt     <= '0;
         gnt     <= '0;
         active  <= 1'b0;
         {num3, num2, num1, num0} <= '0;
         dot_out <= '0;
`ifdef SEG_BLANK_GAP_EN
         gcnt    <= '0;
`endif
      end else if (take) begin
         state   <= SHOW;
         ptr     <= win;
         cnt     <= '0;
         gnt     <= ONE << win;
         active  <= 1'b1;
         {num3, num2, num1, num0} <= sel_data;
         dot_out <= sel_dots;
`ifdef SEG_BLANK_GAP_EN
      end else if (go_gap) begin
         state   <= GAP;
         gcnt    <= '0;
         cnt     <= '0;
         gnt     <= '0;
         active  <= 1'b0;
         {num3, num2, num1, num0} <= '0;
         dot_out <= '0;
`endif
      end else if (go_idle) begin
         state   <= IDLE;
         cnt     <= '0;
         gnt     <= '0;
         active  <= 1'b0;
         {num3, num2, num1, num0} <= '0;
         dot_out <= '0;
      end else if (state == SHOW) begin
         cnt     <= keep ? '0 : cnt + CW'(1);
         {num3, num2, num1, num0} <= sel_data;
         dot_out <= sel_dots;
`ifdef SEG_BLANK_GAP_EN
      end else if (state == GAP) begin
         gcnt    <= gcnt + GW'(1);
`endif
      end
   end

endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int GP = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [63:0] src_data;
   logic [15:0] src_dots;
   logic [3:0]  gnt;
   logic        active;
   logic [3:0]  num3, num2, num1, num0, dot_out;

   seg_display_scheduler #(.N_SRC(N), .DWELL_CYCLES(DW), .GAP_CYCLES(GP)) dut (
      .clk(clk), .reset(reset), .req(req), .src_data(src_data), .src_dots(src_dots),
      .gnt(gnt), .active(active), .num3(num3), .num2(num2), .num1(num1), .num0(num0),
      .dot_out(dot_out)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: owner index (-1 = nothing shown), last winner, cycles
   // held so far, blank cycles still to go.
   int          m_owner, m_ptr, m_held, m_gap;
   logic [15:0] m_num;
   logic [3:0]  m_dot;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 1; k <= N; k++)
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   task automatic grant(input int w);
      m_owner = w; m_ptr = w; m_held = 0;
   endtask

   task automatic handover(input int w);
`ifdef SEG_BLANK_GAP_EN
      m_owner = -1; m_gap = GP;
`else
      grant(w);
`endif
   endtask

   task automatic model_edge();
      int w;
      logic [3:0] mine;
      if (reset) begin
         m_owner = -1; m_ptr = N - 1; m_held = 0; m_gap = 0;
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) begin
            w = pick();
            if (w >= 0) grant(w);
         end
      end else if (m_owner < 0) begin
         w = pick();
         if (w >= 0) grant(w);
      end else if (!req[m_owner]) begin
         w = pick();
         if (w >= 0) handover(w); else m_owner = -1;
      end else if (m_held == DW - 1) begin
         mine = 4'b0001 << m_owner;
         if ((req & ~mine) != 4'b0000) handover(pick());
         else m_held = 0;
      end else begin
         m_held++;
      end
      if (m_owner >= 0) begin
         m_num = src_data[16*m_owner +: 16];
         m_dot = src_dots[4*m_owner +: 4];
      end else begin
         m_num = 16'h0;
         m_dot = 4'h0;
      end
   endtask

   task automatic step();
      logic [3:0] eg;
      @(posedge clk);
      model_edge();
      #1;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("active", 32'(active), 32'(m_owner >= 0));
      chk("nums", 32'({num3, num2, num1, num0}), 32'(m_num));
      chk("dots", 32'(dot_out), 32'(m_dot));
   endtask

   initial begin
      int run;
      m_owner = -1; m_ptr = N - 1; m_held = 0; m_gap = 0; m_num = '0; m_dot = '0;
      reset = 1'b1; req = 4'b0000;
      src_data = 64'h0; src_dots = 16'h0;

      // Reset state
      step(); step();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_active", 32'(active), 32'h0);
      chk("rst_nums", 32'({num3, num2, num1, num0}), 32'h0);
      chk("rst_dots", 32'(dot_out), 32'h0);
      reset = 1'b0;

      // 1: lone source 0
      src_data[15:0] = 16'h1234; src_dots[3:0] = 4'b0100;
      src_data[47:32] = 16'hABCD; src_dots[11:8] = 4'b0011;
      src_data[31:16] = 16'h5E6F; src_dots[7:4] = 4'b1000;
      src_data[63:48] = 16'h9087; src_dots[15:12] = 4'b0001;
      req = 4'b0001;
      step();
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_active", 32'(active), 32'h1);
      chk("t1_nums", 32'({num3, num2, num1, num0}), 32'h1234);
      chk("t1_dots", 32'(dot_out), 32'b0100);
      repeat (20) step();

      // 2: two contenders alternate
      req = 4'b0101;
      repeat (40) step();

      // 3: owner 2 drops at cnt=3 while source 1 waits
      req = 4'b0110;
      for (int i = 0; i < 60 && !(m_owner == 2 && m_held == 3); i++) step();
      chk("t3_reach", 32'(gnt), 32'b0100);
      req = 4'b0010;
      step();
`ifndef SEG_BLANK_GAP_EN
      chk("t3_gnt", 32'(gnt), 32'b0010);
`endif
      req = 4'b0111;
      repeat (3) step();

      // 4: everything drops mid-dwell
      req = 4'b0000;
      step();
`ifndef SEG_BLANK_GAP_EN
      chk("t4_gnt", 32'(gnt), 32'h0);
      chk("t4_active", 32'(active), 32'h0);
      chk("t4_nums", 32'({num3, num2, num1, num0}), 32'h0);
      chk("t4_dots", 32'(dot_out), 32'h0);
`endif
      repeat (5) step();

      // 5: reset mid-grant, then source 0 wins first
      req = 4'b0001;
      for (int i = 0; i < 30 && !(m_owner == 0 && m_held == 5); i++) step();
      chk("t5_reach", 32'(gnt), 32'h1);
      reset = 1'b1;
      step();
      chk("t5_gnt", 32'(gnt), 32'h0);
      chk("t5_nums", 32'({num3, num2, num1, num0}), 32'h0);
      chk("t5_dots", 32'(dot_out), 32'h0);
      reset = 1'b0; req = 4'b1001;
      step();
      chk("t5_first", 32'(gnt), 32'h1);

      // 6: blank run length between owners, then lone re-grant
      req = 4'b0011;
      run = 0;
      for (int i = 0; i < 40; i++) begin
         step();
`ifdef SEG_BLANK_GAP_EN
         if (gnt == 4'b0000) run++;
         else begin
            if (run > 0) chk("t6_gap_len", 32'(run), 32'(GP));
            run = 0;
         end
`else
         chk("t6_no_gap", 32'(active), 32'h1);
`endif
      end
      req = 4'b0001;
      repeat (12) step();
      for (int i = 0; i < 20; i++) begin
         step();
         chk("t6_lone", 32'(gnt), 32'h1);
      end

      // Random traffic against the model
      for (int c = 0; c < 800; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
         if ($urandom_range(0, 7) == 0) begin
            src_data = {$urandom, $urandom};
            src_dots = 16'($urandom);
         end
         reset = ($urandom_range(0, 199) == 0);
         step();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
